seq_mag_cmp: RTL and testbench
==============================

Name: seq_mag_cmp

Overview:
- Parametrised, multi-cycle magnitude comparator; successor to the fixed 2/4/8-bit combinational comparators.
- Compares two WIDTH-bit operands MSB-first, DIGIT bits per clock, and exits early on the first differing digit.
- Supports unsigned and two's-complement modes, selected per request.
- Uses a start/busy/done handshake so it can sit on a datapath next to sequential control logic.

Parameters:
- WIDTH, 8, operand width in bits; must be ≥ 2 and an integer multiple of DIGIT.
- DIGIT, 2, bits compared per cycle; NCHUNK = WIDTH/DIGIT digits per operation.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; accepted only when busy = 0.
- signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  comparison in progress.
- done  output  1  one-cycle pulse when the result becomes valid.
- greater  output  1  A > B (registered, held).
- less  output  1  A < B (registered, held).
- equal  output  1  A == B (registered, held).

Behaviour:
- Reset (rst_n = 0, asynchronous): state = IDLE; busy, done, greater, less and equal = 0; the operand registers and digit index are cleared. All outputs stay at 0 until the first completed compare.
- States:
  - IDLE: busy = 0.
  - RUN: busy = 1.
- IDLE → RUN on a clock edge where start = 1.
  - a and b are latched. If signed_mode = 1, the MSB of both latched copies is inverted (offset-binary), so the unsigned digit compare gives the signed order.
  - Digit index is set to NCHUNK-1.
  - greater, less and equal are cleared to 0.
- RUN, each cycle: compare latched digit [idx*DIGIT +: DIGIT] of A and B.
  - A digit > B digit: greater = 1, done = 1, go to IDLE.
  - A digit < B digit: less = 1, done = 1, go to IDLE.
  - Digits equal and idx = 0: equal = 1, done = 1, go to IDLE.
  - Digits equal and idx > 0: idx decrements, stay in RUN.
- Latency: start sampled at edge t0; result and done register at edge t0+m, where m = number of digits examined (1..NCHUNK). Worst case is NCHUNK cycles.
- Exactly one of greater/less/equal is 1 after done. The result is held until the next accepted start.
- done is high for exactly one cycle. busy falls at the same edge that done rises.
- start with busy = 1 is ignored. It does not restart, and it does not alter operands or mode.
- start in the done cycle (busy = 0) is accepted, giving back-to-back operation with no bubble.
- Changes on a, b or signed_mode while busy have no effect.
- Reset mid-RUN aborts immediately. No done pulse is produced and the results read 0.
- signed_mode = 1 with equal operands gives equal = 1, same as unsigned.
- Outputs are registered only; there is no combinational path from inputs to outputs.

Test Plan:
- WIDTH=8, DIGIT=2, unsigned, a=8'hA5, b=8'h35 → done 1 cycle after start, greater=1, less=0, equal=0.
- a=8'h10, b=8'h11, unsigned → done after 4 cycles, less=1. Then a=b=8'h3C → done after 4 cycles, equal=1.
- a=8'hFF, b=8'h01 → signed_mode=1 gives less=1; signed_mode=0 gives greater=1. a=8'h80, b=8'h7F with signed_mode=1 → less=1.
- start pulsed with a new operand pair while busy → ignored, and the first result is unchanged. start in the done cycle → accepted; second done arrives m cycles later with no gap.
- rst_n driven low 2 cycles into a 4-digit compare → busy, done and all results go to 0 immediately; no done pulse after release.
- WIDTH=4, DIGIT=1 exhaustive sweep of {a,b} = 0..255 in both modes → every result matches golden >, <, ==, and each latency is 1..4 cycles, equal to the index of the first differing bit from the MSB.

Source files
------------

// File: rtl/seq_mag_cmp_if.sv
// Request/result bundle for the sequential magnitude comparator.
// Master drives the operands and start. Slave returns the registered status and result.
interface seq_mag_cmp_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             greater;
    logic             less;
    logic             equal;

    modport master (
        output start, signed_mode, a, b,
        input  busy, done, greater, less, equal
    );

    modport slave (
        input  start, signed_mode, a, b,
        output busy, done, greater, less, equal
    );
endinterface

// File: rtl/seq_mag_cmp.sv
// MSB-first digit-serial magnitude comparator. Latency is 1..WIDTH/DIGIT cycles, with an early exit on the first differing digit.
// start is ignored while busy. Results are registered and held until the next accepted start.
module seq_mag_cmp #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    seq_mag_cmp_if.slave bus
);
    localparam int NCHUNK = WIDTH / DIGIT;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    if (WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_bad_param
        $error("seq_mag_cmp: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [IDXW-1:0]  idx;
    logic             busy_q;
    logic             done_q;
    logic             gt_q;
    logic             lt_q;
    logic             eq_q;
    logic [DIGIT-1:0] dig_a;
    logic [DIGIT-1:0] dig_b;

    // Flipping the sign bit maps two's-complement order onto unsigned order.
    function automatic logic [WIDTH-1:0] to_offset(input logic [WIDTH-1:0] v, input logic sm);
        return {v[WIDTH-1] ^ sm, v[WIDTH-2:0]};
    endfunction

    always_comb begin
        dig_a = op_a[int'(idx)*DIGIT +: DIGIT];
        dig_b = op_b[int'(idx)*DIGIT +: DIGIT];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            op_a   <= '0;
            op_b   <= '0;
            idx    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            gt_q   <= 1'b0;
            lt_q   <= 1'b0;
            eq_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_a   <= to_offset(bus.a, bus.signed_mode);
                        op_b   <= to_offset(bus.b, bus.signed_mode);
                        idx    <= LAST_IDX;
                        gt_q   <= 1'b0;
                        lt_q   <= 1'b0;
                        eq_q   <= 1'b0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (dig_a > dig_b) begin
                        gt_q   <= 1'b1;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else if (dig_a < dig_b) begin
                        lt_q   <= 1'b1;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else if (idx == '0) begin
                        eq_q   <= 1'b1;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.greater = gt_q;
    assign bus.less    = lt_q;
    assign bus.equal   = eq_q;
endmodule

// File: tb/tb_seq_mag_cmp.sv
// Bench for seq_mag_cmp: an 8-bit/2-bit instance driven by directed vectors and a 4-bit/1-bit instance swept exhaustively.
// A cycle-level reference model built from arithmetic compare and first-differing-digit latency is checked every cycle.
module tb_seq_mag_cmp;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seq_mag_cmp_if #(.WIDTH(8)) if8 ();
    seq_mag_cmp_if #(.WIDTH(4)) if4 ();

    seq_mag_cmp #(.WIDTH(8), .DIGIT(2)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
    seq_mag_cmp #(.WIDTH(4), .DIGIT(1)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Result encoding is {greater, less, equal}.
    function automatic logic [2:0] golden(input int unsigned av, input int unsigned bv, input bit sm, input int w);
        int sa = int'(av);
        int sb = int'(bv);
        if (sm && av[w-1]) sa = sa - (1 << w);
        if (sm && bv[w-1]) sb = sb - (1 << w);
        if (sa > sb) return 3'b100;
        if (sa < sb) return 3'b010;
        return 3'b001;
    endfunction

    // The sign flip hits both operands, so a^b (and thus the first differing digit) is mode independent.
    function automatic int latency(input int unsigned av, input int unsigned bv, input int w, input int d);
        int unsigned x = av ^ bv;
        for (int i = w - 1; i >= 0; i--)
            if (x[i]) return (w - 1 - i) / d + 1;
        return w / d;
    endfunction

    bit       m_busy[2] = '{0, 0};
    bit       m_done[2] = '{0, 0};
    logic [2:0] m_res[2] = '{3'b000, 3'b000};
    logic [2:0] m_pend[2] = '{3'b000, 3'b000};
    int       m_cnt[2] = '{0, 0};

    task automatic step(input int k, input bit st, input int unsigned av, input int unsigned bv,
                        input bit sm, input int w, input int d);
        m_done[k] = 1'b0;
        if (m_busy[k]) begin
            m_cnt[k]--;
            if (m_cnt[k] == 0) begin
                m_busy[k] = 1'b0;
                m_done[k] = 1'b1;
                m_res[k]  = m_pend[k];
            end
        end else if (st) begin
            m_busy[k] = 1'b1;
            m_res[k]  = 3'b000;
            m_cnt[k]  = latency(av, bv, w, d);
            m_pend[k] = golden(av, bv, sm, w);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_busy[k] = 1'b0;
                m_done[k] = 1'b0;
                m_res[k]  = 3'b000;
                m_cnt[k]  = 0;
            end
        end else begin
            step(0, if8.start, if8.a, if8.b, if8.signed_mode, 8, 2);
            step(1, if4.start, if4.a, if4.b, if4.signed_mode, 4, 1);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy8", if8.busy, m_busy[0]);
            check("done8", if8.done, m_done[0]);
            check("res8", {if8.greater, if8.less, if8.equal}, m_res[0]);
            check("busy4", if4.busy, m_busy[1]);
            check("done4", if4.done, m_done[1]);
            check("res4", {if4.greater, if4.less, if4.equal}, m_res[1]);
        end
    end

    task automatic start8(input logic [7:0] av, input logic [7:0] bv, input bit sm);
        if8.a = av; if8.b = bv; if8.signed_mode = sm; if8.start = 1'b1;
        @(negedge clk);
        if8.start = 1'b0;
    endtask

    task automatic start4(input logic [3:0] av, input logic [3:0] bv, input bit sm);
        if4.a = av; if4.b = bv; if4.signed_mode = sm; if4.start = 1'b1;
        @(negedge clk);
        if4.start = 1'b0;
    endtask

    task automatic expect8(input string name, input int cyc0, input int exp_lat, input logic [2:0] exp_res);
        int cyc = cyc0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!if8.done && cyc < 12);
        if (!if8.done) check({name, "_timeout"}, 32'd0, 32'd1);
        check({name, "_lat"}, cyc, exp_lat);
        check({name, "_res"}, {if8.greater, if8.less, if8.equal}, exp_res);
    endtask

    task automatic expect4(input string name, input int exp_lat, input logic [2:0] exp_res);
        int cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!if4.done && cyc < 10);
        if (!if4.done) check({name, "_timeout"}, 32'd0, 32'd1);
        check({name, "_lat"}, cyc, exp_lat);
        check({name, "_res"}, {if4.greater, if4.less, if4.equal}, exp_res);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        if8.start = 1'b0; if8.signed_mode = 1'b0; if8.a = '0; if8.b = '0;
        if4.start = 1'b0; if4.signed_mode = 1'b0; if4.a = '0; if4.b = '0;

        check("model_lat_a5_35", latency(32'hA5, 32'h35, 8, 2), 1);
        check("model_lat_10_11", latency(32'h10, 32'h11, 8, 2), 4);
        check("model_sgn_ff_01", golden(32'hFF, 32'h01, 1'b1, 8), 3'b010);
        check("model_uns_ff_01", golden(32'hFF, 32'h01, 1'b0, 8), 3'b100);

        repeat (3) @(negedge clk);
        check("reset8", {if8.busy, if8.done, if8.greater, if8.less, if8.equal}, 5'b0);
        check("reset4", {if4.busy, if4.done, if4.greater, if4.less, if4.equal}, 5'b0);
        rst_n = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);

        start8(8'hA5, 8'h35, 1'b0);
        expect8("a5_35_u", 0, 1, 3'b100);
        @(negedge clk);
        start8(8'h10, 8'h11, 1'b0);
        expect8("10_11_u", 0, 4, 3'b010);
        start8(8'h3C, 8'h3C, 1'b0);                  // issued in the done cycle
        expect8("3c_3c_b2b", 0, 4, 3'b001);
        @(negedge clk);
        start8(8'hFF, 8'h01, 1'b1);
        expect8("ff_01_s", 0, 1, 3'b010);
        start8(8'hFF, 8'h01, 1'b0);
        expect8("ff_01_u", 0, 1, 3'b100);
        start8(8'h80, 8'h7F, 1'b1);
        expect8("80_7f_s", 0, 1, 3'b010);
        start8(8'h3C, 8'h3C, 1'b1);
        expect8("3c_3c_s", 0, 4, 3'b001);

        @(negedge clk);
        start8(8'h10, 8'h11, 1'b0);
        if8.a = 8'hFF; if8.b = 8'h00; if8.signed_mode = 1'b0; if8.start = 1'b1;
        @(negedge clk);
        if8.start = 1'b0;
        expect8("busy_ignore", 1, 4, 3'b010);
        repeat (3) @(negedge clk);
        check("held_res", {if8.done, if8.greater, if8.less, if8.equal}, 4'b0010);

        start8(8'h10, 8'h11, 1'b0);
        @(negedge clk);
        check("pre_reset_busy", if8.busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_outs", {if8.busy, if8.done, if8.greater, if8.less, if8.equal}, 5'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("no_done_after_abort", {if8.done, if8.greater, if8.less, if8.equal}, 4'b0);
        end

        start4(4'b1000, 4'b1001, 1'b0);
        expect4("w4_8_9_u", 4, 3'b010);
        start4(4'b1000, 4'b0111, 1'b1);
        expect4("w4_m8_7_s", 1, 3'b010);
        @(negedge clk);

        for (int sm = 0; sm < 2; sm++) begin
            for (int v = 0; v < 256; v++) begin
                logic [7:0] vv;
                vv = 8'(v);
                start4(vv[7:4], vv[3:0], sm[0]);
                expect4("sweep", latency(32'(vv[7:4]), 32'(vv[3:0]), 4, 1),
                        golden(32'(vv[7:4]), 32'(vv[3:0]), sm[0], 4));
            end
        end

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
